// File: rtl/mem_port_arbiter_if.sv
// Signal bundle linking the IF/MEM pipeline ports, the memory arbiter and the unified memory.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   // Instruction fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;

   // Load/store port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [STRB_W-1:0] d_wstrb;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;

   // Pipeline control
   logic              flush;
   logic              stall_if;
   logic              stall_mem;

   // Memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, flush, mem_rdata, mem_ack,
      output if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, flush, mem_rdata, mem_ack,
      input  if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and load/store.
// Data wins by default; a starvation counter forces a fetch grant; flushed fetches are dropped.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      StIdle,
      StDWait,
      StIWait,
      StIDrop
   } state_e;

   state_e            r_state;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic              r_if_valid;
   logic              r_d_valid;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [STRB_W-1:0] r_mem_wstrb;

   state_e            w_state_next;
   logic [CNT_W-1:0]  w_starve_next;
   logic [CNT_W-1:0]  w_starve_inc;
   logic              w_if_valid_next;
   logic              w_d_valid_next;
   logic [DATA_W-1:0] w_if_rdata_next;
   logic [DATA_W-1:0] w_d_rdata_next;
   logic              w_mem_we_next;
   logic [ADDR_W-1:0] w_mem_addr_next;
   logic [DATA_W-1:0] w_mem_wdata_next;
   logic [STRB_W-1:0] w_mem_wstrb_next;
   logic              w_if_elig;
   logic              w_d_elig;
   logic              w_grant_if;
   logic              w_grant_d;

   // A request whose completion pulse is showing this cycle is the one just served.
   assign w_if_elig    = bus.if_req & ~r_if_valid;
   assign w_d_elig     = bus.d_req & ~r_d_valid;
   assign w_starve_inc = (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + CNT_W'(1);

   always_comb begin
      w_state_next     = r_state;
      w_starve_next    = r_starve_cnt;
      w_if_valid_next  = 1'b0;
      w_d_valid_next   = 1'b0;
      w_if_rdata_next  = r_if_rdata;
      w_d_rdata_next   = r_d_rdata;
      w_mem_we_next    = r_mem_we;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;
      w_mem_wstrb_next = r_mem_wstrb;
      w_grant_if       = 1'b0;
      w_grant_d        = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (w_if_elig && (r_starve_cnt == LIMIT)) begin
               w_grant_if = 1'b1;
            end else if (w_d_elig) begin
               w_grant_d = 1'b1;
            end else if (w_if_elig) begin
               w_grant_if = 1'b1;
            end

            if (w_grant_if) begin
               w_state_next     = StIWait;
               w_starve_next    = '0;
               w_mem_we_next    = 1'b0;
               w_mem_addr_next  = bus.if_addr;
               w_mem_wdata_next = '0;
               w_mem_wstrb_next = '0;
            end else if (w_grant_d) begin
               w_state_next     = StDWait;
               w_starve_next    = w_if_elig ? w_starve_inc : '0;
               w_mem_we_next    = bus.d_we;
               w_mem_addr_next  = bus.d_addr;
               w_mem_wdata_next = bus.d_wdata;
               w_mem_wstrb_next = bus.d_we ? bus.d_wstrb : '0;
            end
         end

         StDWait: begin
            if (bus.mem_ack) begin
               w_state_next   = StIdle;
               w_d_valid_next = 1'b1;
               // Stores leave the last load result untouched.
               if (!r_mem_we) begin
                  w_d_rdata_next = bus.mem_rdata;
               end
            end
         end

         StIWait: begin
            if (bus.mem_ack) begin
               w_state_next = StIdle;
               if (!bus.flush) begin
                  w_if_valid_next = 1'b1;
                  w_if_rdata_next = bus.mem_rdata;
               end
            end else if (bus.flush) begin
               w_state_next = StIDrop;
            end
         end

         StIDrop: begin
            if (bus.mem_ack) begin
               w_state_next = StIdle;
            end
         end

         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_starve_cnt <= '0;
         r_if_valid   <= 1'b0;
         r_d_valid    <= 1'b0;
         r_if_rdata   <= '0;
         r_d_rdata    <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_wstrb  <= '0;
      end else begin
         r_state      <= w_state_next;
         r_starve_cnt <= w_starve_next;
         r_if_valid   <= w_if_valid_next;
         r_d_valid    <= w_d_valid_next;
         r_if_rdata   <= w_if_rdata_next;
         r_d_rdata    <= w_d_rdata_next;
         r_mem_we     <= w_mem_we_next;
         r_mem_addr   <= w_mem_addr_next;
         r_mem_wdata  <= w_mem_wdata_next;
         r_mem_wstrb  <= w_mem_wstrb_next;
      end
   end

   assign bus.mem_req   = (r_state != StIdle);
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wstrb = r_mem_wstrb;

   assign bus.if_valid  = r_if_valid;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.d_valid   = r_d_valid;
   assign bus.d_rdata   = r_d_rdata;

   assign bus.stall_if  = bus.if_req & ~r_if_valid;
   assign bus.stall_mem = bus.d_req & ~r_d_valid;
endmodule
